// File: rtl/sys_ctrl_tx_sched.sv
// Transmit scheduler: queues ALU results (two bytes, low first) and register-read
// bytes into a small FIFO and hands them to the UART Tx under a Valid/Busy handshake.
module sys_ctrl_tx_sched #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] ALU_OUT,
  input  logic        OUT_Valid,
  input  logic [7:0]  RdData,
  input  logic        RdData_Valid,
  input  logic        Busy,
  output logic [7:0]  TX_P_DATA,
  output logic        TX_D_VLD,
  output logic        DROP,
  output logic        TX_TMO,
  output logic        EMPTY
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, XMIT} state_t;

  state_t        state_reg, state_next;
  logic [7:0]    mem_reg  [DEPTH];
  logic [7:0]    mem_next [DEPTH];
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_p1, rd_slot;
  logic [CW-1:0] count_reg, count_next, free;
  logic [TW-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic [7:0]    tx_data_reg, tx_data_next;
  logic          tx_vld_reg, tx_vld_next;
  logic          tmo_reg, tmo_next;
  logic          drop_reg, empty_reg;
  logic          alu_ok, rd_ok, pop;
  logic [CW-1:0] push_n;

  // Capacity is judged on occupancy at the start of the cycle; ALU has priority.
  assign free      = CW'(DEPTH) - count_reg;
  assign alu_ok    = OUT_Valid && (free >= CW'(2));
  assign rd_ok     = RdData_Valid && (OUT_Valid ? (free >= CW'(3)) : (free >= CW'(1)));
  assign push_n    = (alu_ok ? CW'(2) : CW'(0)) + (rd_ok ? CW'(1) : CW'(0));
  assign wr_ptr_p1 = wr_ptr_reg + AW'(1);
  assign rd_slot   = alu_ok ? (wr_ptr_reg + AW'(2)) : wr_ptr_reg;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_comb begin
        mem_next[gi] = mem_reg[gi];
        if (alu_ok && wr_ptr_reg == AW'(gi))
          mem_next[gi] = ALU_OUT[7:0];
        else if (alu_ok && wr_ptr_p1 == AW'(gi))
          mem_next[gi] = ALU_OUT[15:8];
        else if (rd_ok && rd_slot == AW'(gi))
          mem_next[gi] = RdData;
      end
    end
  endgenerate

  always_ff @(posedge CLK) begin
    mem_reg <= mem_next;
  end

  assign wr_ptr_next = wr_ptr_reg + push_n[AW-1:0];
  assign rd_ptr_next = rd_ptr_reg + (pop ? AW'(1) : AW'(0));
  assign count_next  = count_reg + push_n - (pop ? CW'(1) : CW'(0));

  always_comb begin
    state_next   = state_reg;
    tx_data_next = tx_data_reg;
    tx_vld_next  = tx_vld_reg;
    tmo_cnt_next = tmo_cnt_reg;
    tmo_next     = 1'b0;
    pop          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0 && !Busy) begin
          tx_data_next = mem_reg[rd_ptr_reg];
          pop          = 1'b1;
          tx_vld_next  = 1'b1;
          tmo_cnt_next = '0;
          state_next   = REQ;
        end
      end
      REQ: begin
        if (Busy) begin
          tx_vld_next = 1'b0;
          state_next  = XMIT;
        end else if (tmo_cnt_reg == TW'(TIMEOUT - 1)) begin
          // Byte is abandoned, not retried.
          tx_vld_next = 1'b0;
          tmo_next    = 1'b1;
          state_next  = IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + TW'(1);
        end
      end
      XMIT: begin
        if (!Busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg   <= IDLE;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      tmo_cnt_reg <= '0;
      tx_data_reg <= '0;
      tx_vld_reg  <= 1'b0;
      tmo_reg     <= 1'b0;
      drop_reg    <= 1'b0;
      empty_reg   <= 1'b1;
    end else begin
      state_reg   <= state_next;
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      tmo_cnt_reg <= tmo_cnt_next;
      tx_data_reg <= tx_data_next;
      tx_vld_reg  <= tx_vld_next;
      tmo_reg     <= tmo_next;
      drop_reg    <= (OUT_Valid && !alu_ok) || (RdData_Valid && !rd_ok);
      empty_reg   <= (state_reg == IDLE) && (count_reg == '0);
    end
  end

  assign TX_P_DATA = tx_data_reg;
  assign TX_D_VLD  = tx_vld_reg;
  assign DROP      = drop_reg;
  assign TX_TMO    = tmo_reg;
  assign EMPTY     = empty_reg;

endmodule

// File: tb/tb_sys_ctrl_tx_sched.sv
// Scoreboard bench for sys_ctrl_tx_sched: expected bytes are queued as requests are
// driven and popped as a modelled UART Tx accepts each frame.
module tb_sys_ctrl_tx_sched;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        OUT_Valid = 1'b0;
  logic [7:0]  RdData = '0;
  logic        RdData_Valid = 1'b0;
  logic        Busy = 1'b0;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        DROP;
  logic        TX_TMO;
  logic        EMPTY;

  int errors = 0;
  int checks = 0;
  logic [7:0] sb[$];

  sys_ctrl_tx_sched #(.DEPTH(8), .TIMEOUT(15)) dut (
    .CLK(CLK), .RST(RST), .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid),
    .RdData(RdData), .RdData_Valid(RdData_Valid), .Busy(Busy),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .DROP(DROP),
    .TX_TMO(TX_TMO), .EMPTY(EMPTY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drives one request cycle; expected bytes enter the scoreboard only if acceptance is expected.
  task automatic req(input bit alu, input logic [15:0] a, input bit rd, input logic [7:0] d,
                     input bit exp_alu, input bit exp_rd);
    ALU_OUT = a; OUT_Valid = alu; RdData = d; RdData_Valid = rd;
    if (alu && exp_alu) begin sb.push_back(a[7:0]); sb.push_back(a[15:8]); end
    if (rd && exp_rd) sb.push_back(d);
    tick();
    OUT_Valid = 1'b0; RdData_Valid = 1'b0;
  endtask

  task automatic wait_vld(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge CLK);
      if (TX_D_VLD === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_vld: got TX_D_VLD=0 for 100 cycles, expected 1");
    end
  endtask

  // Models the UART Tx: Busy one cycle after the request, held for 10 cycles.
  task automatic serve(input int n);
    bit ok;
    bit stable;
    logic [7:0] cap, exp_b;
    for (int i = 0; i < n; i++) begin
      wait_vld(ok);
      if (!ok) return;
      cap = TX_P_DATA;
      stable = 1'b1;
      tick();
      Busy = 1'b1;
      for (int j = 0; j < 10; j++) begin
        @(negedge CLK);
        if (TX_P_DATA !== cap) stable = 1'b0;
        if (j == 1) begin
          checks++;
          if (TX_D_VLD !== 1'b0) begin
            errors++;
            $display("FAIL vld_fall: got TX_D_VLD=%b, expected 0 once Busy sampled", TX_D_VLD);
          end
        end
      end
      tick();
      Busy = 1'b0;
      checks++;
      if (!stable) begin
        errors++;
        $display("FAIL data_stable: byte %h changed during frame, expected held", cap);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: got byte %h, expected no byte", cap);
      end else begin
        exp_b = sb.pop_front();
        if (cap !== exp_b) begin
          errors++;
          $display("FAIL tx_byte: got %h, expected %h", cap, exp_b);
        end
        $display("frame: sent %h expected %h", cap, exp_b);
      end
    end
  endtask

  task automatic check_quiet(input int n, input string name);
    bit rose = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (TX_D_VLD !== 1'b0) rose = 1'b1;
    end
    checks++;
    if (rose) begin
      errors++;
      $display("FAIL %s_quiet: got TX_D_VLD=1, expected no request", name);
    end
    checks++;
    if (EMPTY !== 1'b1) begin
      errors++;
      $display("FAIL %s_empty: got EMPTY=%b, expected 1", name, EMPTY);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    checks++;
    if ({TX_P_DATA, TX_D_VLD, DROP, TX_TMO, EMPTY} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h vld=%b drop=%b tmo=%b empty=%b, expected 00 0 0 0 1",
               TX_P_DATA, TX_D_VLD, DROP, TX_TMO, EMPTY);
    end
    tick();
    RST = 1'b1;
    check_quiet(20, "reset");
    $display("reset: released, idle");
  endtask

  task automatic test_alu();
    tick();
    req(1'b1, 16'hA55A, 1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge CLK);
    checks++;
    if (TX_D_VLD !== 1'b0) begin
      errors++;
      $display("FAIL alu_latency1: got TX_D_VLD=%b after 1 edge, expected 0", TX_D_VLD);
    end
    @(negedge CLK);
    checks++;
    if (TX_D_VLD !== 1'b1) begin
      errors++;
      $display("FAIL alu_latency2: got TX_D_VLD=%b after 2 edges, expected 1", TX_D_VLD);
    end
    serve(2);
  endtask

  task automatic test_simultaneous();
    tick();
    req(1'b1, 16'h1234, 1'b1, 8'h77, 1'b1, 1'b1);
    @(negedge CLK);
    checks++;
    if (DROP !== 1'b0) begin
      errors++;
      $display("FAIL simul_drop: got DROP=%b, expected 0", DROP);
    end
    serve(3);
  endtask

  task automatic test_overflow();
    tick();
    Busy = 1'b1;
    tick(); tick();
    for (int i = 1; i <= 4; i++)
      req(1'b1, {4'(i), 4'(i), 4'(i), 4'(i + 8)}, 1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge CLK);
    checks++;
    if (DROP !== 1'b0) begin
      errors++;
      $display("FAIL ovf_fill_drop: got DROP=%b, expected 0", DROP);
    end
    tick();
    req(1'b0, 16'h0000, 1'b1, 8'h99, 1'b0, 1'b0);
    @(negedge CLK);
    checks++;
    if (DROP !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drop: got DROP=%b, expected 1", DROP);
    end
    @(negedge CLK);
    checks++;
    if (DROP !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drop_pulse: got DROP=%b, expected 0 one cycle later", DROP);
    end
    tick();
    Busy = 1'b0;
    serve(8);
    check_quiet(20, "ovf");
  endtask

  task automatic test_atomic();
    tick();
    Busy = 1'b1;
    tick(); tick();
    for (int i = 0; i < 7; i++)
      req(1'b0, 16'h0000, 1'b1, 8'h40 + 8'(i), 1'b0, 1'b1);
    req(1'b1, 16'hBEEF, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge CLK);
    checks++;
    if (DROP !== 1'b1) begin
      errors++;
      $display("FAIL atomic_drop: got DROP=%b, expected 1", DROP);
    end
    tick();
    // One free entry must remain if nothing from 0xBEEF was written.
    req(1'b0, 16'h0000, 1'b1, 8'h47, 1'b0, 1'b1);
    @(negedge CLK);
    checks++;
    if (DROP !== 1'b0) begin
      errors++;
      $display("FAIL atomic_room: got DROP=%b, expected 0 for 8th byte", DROP);
    end
    tick();
    Busy = 1'b0;
    serve(8);
    check_quiet(20, "atomic");
  endtask

  task automatic test_timeout();
    bit ok;
    int hi;
    logic [7:0] lost;
    tick();
    req(1'b1, 16'hC33C, 1'b0, 8'h00, 1'b1, 1'b0);
    wait_vld(ok);
    if (ok) begin
      hi = 1;
      for (int i = 0; i < 40; i++) begin
        @(negedge CLK);
        if (TX_D_VLD !== 1'b1) break;
        hi++;
      end
      checks++;
      if (hi != 15) begin
        errors++;
        $display("FAIL tmo_len: got TX_D_VLD high %0d cycles, expected 15", hi);
      end
      checks++;
      if (TX_TMO !== 1'b1) begin
        errors++;
        $display("FAIL tmo_pulse: got TX_TMO=%b, expected 1", TX_TMO);
      end
      @(negedge CLK);
      checks++;
      if (TX_TMO !== 1'b0) begin
        errors++;
        $display("FAIL tmo_once: got TX_TMO=%b, expected 0", TX_TMO);
      end
      lost = sb.pop_front();
      $display("timeout: byte %h discarded after %0d cycles", lost, hi);
      serve(1);
    end
  endtask

  task automatic test_reset_xmit();
    bit ok;
    tick();
    req(1'b0, 16'h0000, 1'b1, 8'h5E, 1'b0, 1'b1);
    req(1'b0, 16'h0000, 1'b1, 8'hE5, 1'b0, 1'b1);
    wait_vld(ok);
    tick();
    Busy = 1'b1;
    tick(); tick(); tick();
    RST = 1'b0;
    #1;
    checks++;
    if ({TX_P_DATA, TX_D_VLD, DROP, TX_TMO, EMPTY} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL xmit_reset: got data=%h vld=%b drop=%b tmo=%b empty=%b, expected 00 0 0 0 1",
               TX_P_DATA, TX_D_VLD, DROP, TX_TMO, EMPTY);
    end
    sb.delete();
    tick(); tick();
    RST = 1'b1;
    Busy = 1'b0;
    check_quiet(20, "xmit_reset");
    $display("reset_xmit: reset applied mid-frame");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_simultaneous();
    test_overflow();
    test_atomic();
    test_timeout();
    test_reset_xmit();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d unsent bytes, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
